exc_detect_pipe: RTL

- Producer side of the CP0 exception interface. Detects exceptions in IF, ID and EX, and carries them with the PC and branch-delay-slot (BD) flag through the ID/EX/MEM stage registers.
- Resolves per-instruction priority so that MEM presents at most one exception code to the CP0 block.
- Flushes all stages when CP0 asserts its pipeline-clear, and gates data-memory side effects of excepting instructions.

---
 rtl/exc_detect_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/exc_detect_pipe.sv
// exc_detect_pipe
//   Producer side of the CP0 exception interface. Detects exceptions in
//   IF (fetch address error), ID (RI/SYSCALL/BREAK) and EX (overflow, data
//   address error), and carries code, bad address, PC, delay-slot flag and
//   ERET marker through the ID/EX/MEM stage registers. The earliest
//   exception of an instruction wins, so MEM presents at most one code.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   flush              CP0 pipeline clear; kills ID/EX/MEM at the next edge
//   if_valid/pc/bd     fetch-stage instruction
//   if_allowin         ID accepts from IF this cycle (forced 1 during flush)
//   id_ri/sys/bp/eret  ID decode flags for the instruction leaving ID
//   id_ready_go        ID has no hazard stall
//   ex_ready_go        EX has finished (e.g. divider)
//   ex_ov/ld/st/size/addr  EX overflow and memory access description
//   ex_mem_kill        suppress the data-memory request this cycle
//   mem_allowin        commit stage accepts from MEM
//   id/ex/mem_valid    stage valid bits
//   mem_exc/exc_code/badvaddr/bd/eret/pc  MEM payload, qualified by mem_valid
module exc_detect_pipe #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_bd,
  output logic        if_allowin,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        id_eret,
  input  logic        id_ready_go,
  input  logic        ex_ready_go,
  input  logic        ex_ov,
  input  logic        ex_ld,
  input  logic        ex_st,
  input  logic [1:0]  ex_size,
  input  logic [31:0] ex_addr,
  output logic        ex_mem_kill,
  input  logic        mem_allowin,
  output logic        id_valid,
  output logic        ex_valid,
  output logic        mem_valid,
  output logic        mem_exc,
  output logic [4:0]  mem_exc_code,
  output logic [31:0] mem_badvaddr,
  output logic        mem_bd,
  output logic        mem_eret,
  output logic [31:0] mem_pc
);

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // stage registers
  logic        r_id_valid, r_id_bd, r_id_exc;
  logic [4:0]  r_id_code;
  logic [31:0] r_id_pc, r_id_bva;
  logic        r_ex_valid, r_ex_bd, r_ex_exc, r_ex_eret;
  logic [4:0]  r_ex_code;
  logic [31:0] r_ex_pc, r_ex_bva;
  logic        r_mem_valid, r_mem_bd, r_mem_exc, r_mem_eret;
  logic [4:0]  r_mem_code;
  logic [31:0] r_mem_pc, r_mem_bva;

  // handshake
  logic w_mem_allowin, w_ex_allowin, w_id_allowin;
  logic w_id_to_ex, w_ex_to_mem;

  assign w_mem_allowin = !r_mem_valid | mem_allowin;
  assign w_ex_allowin  = !r_ex_valid  | (ex_ready_go & w_mem_allowin);
  assign w_id_allowin  = !r_id_valid  | (id_ready_go & w_ex_allowin);
  assign w_id_to_ex    = r_id_valid & id_ready_go;
  assign w_ex_to_mem   = r_ex_valid & ex_ready_go;
  assign if_allowin    = w_id_allowin | flush;

  // IF detection: fetch address must be word aligned
  logic w_if_exc;
  assign w_if_exc = |if_pc[1:0];

  // ID detection; a carried IF exception keeps its code and address
  logic       w_id_det, w_id_exc, w_id_eret;
  logic [4:0] w_id_det_code, w_id_code;
  assign w_id_det      = id_ri | id_sys | id_bp;
  assign w_id_det_code = id_ri ? EXC_RI : (id_sys ? EXC_SYS : EXC_BP);
  assign w_id_exc      = r_id_exc | w_id_det;
  assign w_id_code     = r_id_exc ? r_id_code : w_id_det_code;
  // an instruction that already faults never behaves as ERET
  assign w_id_eret     = id_eret & !w_id_exc;

  // EX detection: overflow beats data address error
  logic        w_ex_mis, w_ex_ade, w_ex_det, w_ex_exc, w_ex_eret;
  logic [4:0]  w_ex_det_code, w_ex_code;
  logic [31:0] w_ex_bva;
  always_comb begin
    w_ex_mis = 1'b0;
    case (ex_size)
      2'd0:    w_ex_mis = 1'b0;
      2'd1:    w_ex_mis = ex_addr[0];
      default: w_ex_mis = |ex_addr[1:0];
    endcase
  end
  assign w_ex_ade      = (ex_ld | ex_st) & w_ex_mis;
  assign w_ex_det      = ex_ov | w_ex_ade;
  assign w_ex_det_code = ex_ov ? EXC_OV : (ex_ld ? EXC_ADEL : EXC_ADES);
  assign w_ex_exc      = r_ex_exc | w_ex_det;
  assign w_ex_code     = r_ex_exc ? r_ex_code : w_ex_det_code;
  // overflow has no faulting address, so the carried value passes through
  assign w_ex_bva      = (r_ex_exc | ex_ov) ? r_ex_bva : ex_addr;
  assign w_ex_eret     = r_ex_eret & !w_ex_det;

  // kill the data access of a faulting/ERET instruction in EX, and of any
  // younger access while such an instruction sits in MEM
  assign ex_mem_kill = (r_ex_valid & (r_ex_exc | w_ex_det | r_ex_eret)) |
                       (r_mem_valid & (r_mem_exc | r_mem_eret));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_id_valid  <= 1'b0;  r_id_bd  <= 1'b0;  r_id_exc  <= 1'b0;
      r_id_code   <= '0;    r_id_pc  <= RESET_PC; r_id_bva <= '0;
      r_ex_valid  <= 1'b0;  r_ex_bd  <= 1'b0;  r_ex_exc  <= 1'b0;
      r_ex_eret   <= 1'b0;  r_ex_code <= '0;   r_ex_pc   <= RESET_PC;
      r_ex_bva    <= '0;
      r_mem_valid <= 1'b0;  r_mem_bd <= 1'b0;  r_mem_exc <= 1'b0;
      r_mem_eret  <= 1'b0;  r_mem_code <= '0;  r_mem_pc  <= RESET_PC;
      r_mem_bva   <= '0;
    end else if (flush) begin
      r_id_valid  <= 1'b0;
      r_id_exc    <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_ex_exc    <= 1'b0;
      r_ex_eret   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_exc   <= 1'b0;
      r_mem_eret  <= 1'b0;
    end else begin
      if (w_id_allowin) begin
        r_id_valid <= if_valid;
        if (if_valid) begin
          r_id_pc   <= if_pc;
          r_id_bd   <= if_bd;
          r_id_exc  <= w_if_exc;
          r_id_code <= w_if_exc ? EXC_ADEL : 5'h00;
          r_id_bva  <= w_if_exc ? if_pc : 32'h0;
        end
      end
      if (w_ex_allowin) begin
        r_ex_valid <= w_id_to_ex;
        if (w_id_to_ex) begin
          r_ex_pc   <= r_id_pc;
          r_ex_bd   <= r_id_bd;
          r_ex_exc  <= w_id_exc;
          r_ex_code <= w_id_code;
          r_ex_bva  <= r_id_bva;
          r_ex_eret <= w_id_eret;
        end
      end
      if (w_mem_allowin) begin
        r_mem_valid <= w_ex_to_mem;
        if (w_ex_to_mem) begin
          r_mem_pc   <= r_ex_pc;
          r_mem_bd   <= r_ex_bd;
          r_mem_exc  <= w_ex_exc;
          r_mem_code <= w_ex_code;
          r_mem_bva  <= w_ex_bva;
          r_mem_eret <= w_ex_eret;
        end
      end
    end
  end

  assign id_valid     = r_id_valid;
  assign ex_valid     = r_ex_valid;
  assign mem_valid    = r_mem_valid;
  assign mem_exc      = r_mem_exc;
  assign mem_exc_code = r_mem_code;
  assign mem_badvaddr = r_mem_bva;
  assign mem_bd       = r_mem_bd;
  assign mem_eret     = r_mem_eret;
  assign mem_pc       = r_mem_pc;

endmodule
